fb_write_scheduler: RTL

Write-port controller for the framebuffer RAM (newram4, port A: 12-bit address, 2-bit data). It shares the single write port between two sources: external pixel writes on a valid/ready stream, and an internal fill engine that clears or fills the whole RAM with one value. It sits between the command/UART pixel path and the RAM. Port B (display scan-out) is not touched.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_fill_counter.sv | 57 +++++
 rtl/fb_write_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer write-port scheduler: default RAM
// port A geometry, the scheduler state encoding and the last fill address.
// No ports (package).
// -----------------------------------------------------------------------------
package fb_pkg;

   localparam int FB_ADDR_W     = 12;
   localparam int FB_DATA_W     = 2;
   localparam int FB_FILL_BURST = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fb_state_t;

   // Highest address a fill writes for a given address width.
   function automatic int fb_fill_last(input int aw);
      return (1 << aw) - 1;
   endfunction

   localparam int FB_FILL_LAST = fb_fill_last(FB_ADDR_W);

endpackage

// File: rtl/fb_fill_counter.sv
// -----------------------------------------------------------------------------
// fb_fill_counter
// Fill address counter plus saturating burst counter for the fill engine.
//   clk, reset     : clock, asynchronous active-low reset
//   clear          : restart at address 0 with an empty burst
//   advance        : a fill write was loaded this edge (count address + burst)
//   hold           : a pixel took this slot (address holds, burst clears)
//   fill_addr      : address of the next fill write
//   fill_last      : next fill write is the last address of the RAM
//   slot_open      : FILL_BURST fill writes done since the last pixel/start
// -----------------------------------------------------------------------------
module fb_fill_counter
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int FILL_BURST = FB_FILL_BURST
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance,
   input  logic              hold,
   output logic [ADDR_W-1:0] fill_addr,
   output logic              fill_last,
   output logic              slot_open
);

   localparam int              CNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(fb_fill_last(ADDR_W));
   localparam logic [7:0]      BURST_LIM = 8'(FILL_BURST);

   // One extra bit so the counter never aliases back onto address 0.
   logic [CNT_W-1:0] cnt;
   logic [7:0]       burst;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         burst <= '0;
      end else if (clear) begin
         cnt   <= '0;
         burst <= '0;
      end else if (hold) begin
         burst <= '0;
      end else if (advance) begin
         cnt <= cnt + 1'b1;
         if (burst != 8'hFF) begin
            burst <= burst + 8'd1;
         end
      end
   end

   assign fill_addr = cnt[ADDR_W-1:0];
   assign fill_last = (cnt == LAST);
   assign slot_open = (burst >= BURST_LIM);

endmodule

// File: rtl/fb_write_scheduler.sv
// -----------------------------------------------------------------------------
// fb_write_scheduler
// Shares framebuffer RAM port A between a pixel write stream and a fill engine
// that writes one value to every address.
//   clk, reset            : clock, asynchronous active-low reset
//   pix_valid/pix_ready   : pixel handshake; pix_addr/pix_data the pixel
//   fill_start/fill_value : one-cycle fill request and its value
//   fill_busy             : fill in progress
//   fill_done             : high in the cycle the last fill write is on ram_a_*
//   ram_a_*               : registered RAM port A write interface
//   dbg_state             : current scheduler state
//
// Handshake: a pixel transfers on the rising clk edge where pix_valid and
// pix_ready are both high; pix_ready never depends on pix_valid, and the
// source must hold addr/data stable while pix_valid is high and unaccepted.
//
// Build option FB_WRITE_SCHEDULER_PIXEL_YIELD_EN: when defined, a pending pixel
// may take one slot after every FILL_BURST fill writes; otherwise pixels are
// only accepted while idle.
// -----------------------------------------------------------------------------
module fb_write_scheduler
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int FILL_BURST = FB_FILL_BURST
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [ADDR_W-1:0] pix_addr,
   input  logic [DATA_W-1:0] pix_data,
   input  logic              fill_start,
   input  logic [DATA_W-1:0] fill_value,
   output logic              fill_busy,
   output logic              fill_done,
   output logic [ADDR_W-1:0] ram_a_address,
   output logic [DATA_W-1:0] ram_a_data_in,
   output logic              ram_a_wr,
   output logic              ram_a_clk_enable,
   output fb_state_t         dbg_state
);

`ifdef FB_WRITE_SCHEDULER_PIXEL_YIELD_EN
   localparam logic YIELD_EN = 1'b1;
`else
   localparam logic YIELD_EN = 1'b0;
`endif

   fb_state_t         state;
   logic [DATA_W-1:0] fill_val;
   logic [ADDR_W-1:0] fill_addr;
   logic              fill_last;
   logic              slot_open;
   logic              pix_fire;
   logic              cnt_clear;
   logic              cnt_advance;
   logic              cnt_hold;

   // The clock-enable register doubles as "out of reset", keeping pix_ready
   // low until the first edge after reset release.
   assign pix_ready = ram_a_clk_enable &
                      ((state == ST_IDLE) | (YIELD_EN & (state == ST_FILL) & slot_open));
   assign pix_fire  = pix_valid & pix_ready;
   assign fill_busy = (state == ST_FILL);
   assign dbg_state = state;

   // fill_start during FILL is ignored, so only an idle start clears.
   assign cnt_clear   = (state == ST_IDLE) & fill_start;
   assign cnt_hold    = (state == ST_FILL) & pix_fire;
   assign cnt_advance = (state == ST_FILL) & ~pix_fire;

   fb_fill_counter #(
      .ADDR_W     (ADDR_W),
      .FILL_BURST (FILL_BURST)
   ) u_fill_counter (
      .clk       (clk),
      .reset     (reset),
      .clear     (cnt_clear),
      .advance   (cnt_advance),
      .hold      (cnt_hold),
      .fill_addr (fill_addr),
      .fill_last (fill_last),
      .slot_open (slot_open)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= ST_IDLE;
         fill_val         <= '0;
         ram_a_address    <= '0;
         ram_a_data_in    <= '0;
         ram_a_wr         <= 1'b0;
         ram_a_clk_enable <= 1'b0;
         fill_done        <= 1'b0;
      end else begin
         ram_a_clk_enable <= 1'b1;
         ram_a_wr         <= 1'b0;
         fill_done        <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (pix_fire) begin
                  ram_a_address <= pix_addr;
                  ram_a_data_in <= pix_data;
                  ram_a_wr      <= 1'b1;
               end
               if (fill_start) begin
                  fill_val <= fill_value;
                  state    <= ST_FILL;
               end
            end
            ST_FILL: begin
               // A granted pixel takes the slot; the fill resumes next edge.
               if (pix_fire) begin
                  ram_a_address <= pix_addr;
                  ram_a_data_in <= pix_data;
                  ram_a_wr      <= 1'b1;
               end else begin
                  ram_a_address <= fill_addr;
                  ram_a_data_in <= fill_val;
                  ram_a_wr      <= 1'b1;
                  if (fill_last) begin
                     fill_done <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
